// File: rtl/l5_ram_sync.sv
// rtl/l5_ram_sync.sv - parametrised single-port RAM with clear engine and registered reads
module l5_ram_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                acc_rd;
  logic                acc_wr;

  assign acc_rd = (state_q == READY) && cs && !we;
  assign acc_wr = (state_q == READY) && cs && we;

  // Next-state for the clear FSM, read register and status flags
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_ADDR) begin
        state_d = READY;
        busy_d  = 1'b0;
      end
    end else if (acc_rd) begin
      rdata_d    = mem_q[a];
      rd_valid_d = 1'b1;
    end
  end

  // Memory write port: clear engine owns it while clearing, requester afterwards.
  // Gated by rst_n so nothing is written on an edge that coincides with reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = a;
    mem_wdata = di;
    if (state_q == CLEAR) begin
      mem_we    = rst_n;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (acc_wr) begin
      mem_we    = rst_n;
    end
  end

  // FSM and registered outputs; reset restarts the clear from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array, no reset: contents are defined only by the clear engine
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign dout     = oe ? rdata_q : '0;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_l5_ram_sync.sv
// tb/tb_l5_ram_sync.sv - directed self-checking bench for l5_ram_sync
`timescale 1ns/1ps
module tb_l5_ram_sync;

  logic        clk;
  // instance A: 8 x 64
  logic        rst_n, cs, we, oe;
  logic [5:0]  a;
  logic [7:0]  di, dout;
  logic        rd_valid, busy;
  // instance B: 16 x 8
  logic        b_rst_n, b_cs, b_we, b_oe;
  logic [2:0]  b_a;
  logic [15:0] b_di, b_dout;
  logic        b_rd_valid, b_busy;

  int n_checks;
  int n_errors;

  l5_ram_sync #(.DATA_W(8), .ADDR_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .oe(oe),
    .a(a), .di(di), .dout(dout), .rd_valid(rd_valid), .busy(busy)
  );

  l5_ram_sync #(.DATA_W(16), .ADDR_W(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .cs(b_cs), .we(b_we), .oe(b_oe),
    .a(b_a), .di(b_di), .dout(b_dout), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // count edges until busy drops on instance A, bounded
  task automatic wait_clear_a(output int n);
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic write_a(input logic [5:0] addr, input logic [7:0] data);
    cs = 1'b1; we = 1'b1; a = addr; di = data;
    cyc();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic read_a(input logic [5:0] addr);
    cs = 1'b1; we = 1'b0; a = addr;
    cyc();
    cs = 1'b0;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b1; a = '0; di = '0;
    b_rst_n = 1'b0; b_cs = 1'b0; b_we = 1'b0; b_oe = 1'b1; b_a = '0; b_di = '0;
    cyc(); cyc();

    // reset values
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);

    // release reset, attempt a write to addr 5 while clearing
    rst_n = 1'b1;
    cs = 1'b1; we = 1'b1; a = 6'd5; di = 8'hFF;
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
      if (n == 3) begin cs = 1'b0; we = 1'b0; end
    end
    check("clear_len", 32'(n), 32'd64);
    check("busy_after_clear", 32'(busy), 32'h0);

    // every word reads zero with a single rd_valid pulse
    for (int i = 0; i < 64; i++) begin
      read_a(6'(i));
      check($sformatf("clr_dout[%0d]", i), 32'(dout), 32'h0);
      check($sformatf("clr_rdv[%0d]", i), 32'(rd_valid), 32'h1);
      cyc();
      check($sformatf("clr_rdv_off[%0d]", i), 32'(rd_valid), 32'h0);
    end

    // blocked write during clear left addr 5 zero
    read_a(6'd5);
    check("blocked_addr5", 32'(dout), 32'h0);

    // write/read
    write_a(6'h3F, 8'hA5);
    check("wr_no_rdv", 32'(rd_valid), 32'h0);
    check("wr_rdata_hold", 32'(dout), 32'h0);
    write_a(6'h00, 8'h5A);
    read_a(6'h3F);
    check("rd_3f", 32'(dout), 32'hA5);
    check("rd_3f_rdv", 32'(rd_valid), 32'h1);
    read_a(6'h00);
    check("rd_00", 32'(dout), 32'h5A);
    check("rd_00_rdv", 32'(rd_valid), 32'h1);

    // oe gating
    oe = 1'b0;
    read_a(6'h3F);
    check("oe0_dout", 32'(dout), 32'h0);
    check("oe0_rdv", 32'(rd_valid), 32'h1);
    #2 oe = 1'b1;
    #1;
    check("oe1_same_cycle", 32'(dout), 32'hA5);
    cyc();
    check("oe1_hold_dout", 32'(dout), 32'hA5);
    check("oe1_rdv_off", 32'(rd_valid), 32'h0);

    // reset mid-clear at clear cycle 20
    rst_n = 1'b0;
    #2;
    check("rst2_dout", 32'(dout), 32'h0);
    check("rst2_busy", 32'(busy), 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    check("midclear_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    cyc();
    check("midclear_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b1;
    wait_clear_a(n);
    check("midclear_len", 32'(n), 32'd64);

    // reset mid-operation wipes stored data
    write_a(6'd3, 8'h77);
    read_a(6'd3);
    check("rd_77", 32'(dout), 32'h77);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    wait_clear_a(n);
    check("midop_len", 32'(n), 32'd64);
    read_a(6'd3);
    check("midop_addr3", 32'(dout), 32'h0);
    read_a(6'h3F);
    check("midop_addr3f", 32'(dout), 32'h0);

    // parameter sweep instance
    b_rst_n = 1'b1;
    n = 0;
    while (b_busy && n < 100) begin
      cyc();
      n++;
    end
    check("b_clear_len", 32'(n), 32'd8);
    b_cs = 1'b1; b_we = 1'b1; b_a = 3'd7; b_di = 16'hBEEF;
    cyc();
    check("b_wr_no_rdv", 32'(b_rd_valid), 32'h0);
    b_we = 1'b0;
    cyc();
    b_cs = 1'b0;
    check("b_rd_7", 32'(b_dout), 32'hBEEF);
    check("b_rd_7_rdv", 32'(b_rd_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      b_a = 3'(i);
      cyc();
      check($sformatf("b_idle_rdv[%0d]", i), 32'(b_rd_valid), 32'h0);
      check($sformatf("b_idle_dout[%0d]", i), 32'(b_dout), 32'hBEEF);
    end
    b_cs = 1'b1; b_a = 3'd0;
    cyc();
    b_cs = 1'b0;
    check("b_rd_0", 32'(b_dout), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
